keypad_matrix_emulator: RTL and testbench

Synthesizable 4x4 hexadecimal keypad model that is the responder side of the row-scan/column-sense interface used by the keypad scanner. It watches the scanner's active row and drives active-low column lines as a real contact matrix would, including deterministic pseudo-random contact bounce on press and release. It is used for hardware-in-the-loop checking of the scanner and debouncer on the FPGA, and as a reusable stimulus model on benches.

---
 rtl/keypad_emu_pkg.sv | 24 ++
 rtl/keypad_matrix_emulator_lfsr8.sv | 17 +
 rtl/keypad_matrix_emulator.sv | 126 ++++++++++++
 tb/tb_keypad_matrix_emulator.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/keypad_emu_pkg.sv
// Shared types and helpers for the 4x4 keypad matrix emulator.
package keypad_emu_pkg;

    typedef enum logic [1:0] {
        IDLE           = 2'd0,
        BOUNCE_PRESS   = 2'd1,
        HELD           = 2'd2,
        BOUNCE_RELEASE = 2'd3
    } state_t;

    // Fibonacci taps for x^8+x^6+x^5+x^4+1 on a left-shifting register (bits 7,5,4,3).
    localparam logic [7:0] LFSR_TAPS = 8'b1011_1000;

    localparam logic [3:0] COLS_IDLE = 4'b1111;

    function automatic logic [1:0] key_row(input logic [3:0] key_code);
        return key_code[3:2];
    endfunction

    function automatic logic [1:0] key_col(input logic [3:0] key_code);
        return key_code[1:0];
    endfunction

endpackage

// File: rtl/keypad_matrix_emulator_lfsr8.sv
// Free-running 8-bit Fibonacci LFSR; provides the contact-bounce noise source.
module lfsr8
    import keypad_emu_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] seed,
    output logic [7:0] q
);

    // NOTE: sequential state is assigned with <= so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) q <= seed;
        else       q <= {q[6:0], ^(q & LFSR_TAPS)};
    end

endmodule

// File: rtl/keypad_matrix_emulator.sv
// Responder-side 4x4 keypad model: drives active-low columns for the scanned row.
// Contact bounce is built only when KEYPAD_EMU_BOUNCE_EN is defined.
module keypad_matrix_emulator
    import keypad_emu_pkg::*;
#(
    parameter int         BOUNCE_CYCLES = 64,
    parameter int         TOGGLE_DIV    = 4,
    parameter logic [7:0] LFSR_SEED     = 8'hA5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] current_row,
    input  logic [3:0] key_code,
    input  logic       press_req,
    input  logic       release_req,
    output logic [3:0] cols,
    output logic       busy,
    output logic       done
);

    state_t     state;
    logic       contact;
    logic [1:0] row_q;
    logic [1:0] col_q;

`ifdef KEYPAD_EMU_BOUNCE_EN
    localparam int              CNT_W    = $clog2(BOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BOUNCE_CYCLES - 1);

    logic [CNT_W-1:0] cnt;
    logic [7:0]       lfsr_q;
    logic             sample_now;

    lfsr8 u_lfsr (
        .clk   (clk),
        .reset (reset),
        .seed  (LFSR_SEED),
        .q     (lfsr_q)
    );

    assign sample_now = (int'(cnt) % TOGGLE_DIV) == 0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            contact <= 1'b0;
            row_q   <= '0;
            col_q   <= '0;
            cnt     <= '0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    contact <= 1'b0;
                    if (press_req) begin
                        row_q <= key_row(key_code);
                        col_q <= key_col(key_code);
                        cnt   <= '0;
                        state <= BOUNCE_PRESS;
                    end
                end
                BOUNCE_PRESS, BOUNCE_RELEASE: begin
                    // The window closes on its last count, so cnt never passes CNT_LAST.
                    if (cnt == CNT_LAST) begin
                        contact <= (state == BOUNCE_PRESS);
                        state   <= (state == BOUNCE_PRESS) ? HELD : IDLE;
                        done    <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                        if (sample_now) contact <= lfsr_q[0];
                    end
                end
                HELD: begin
                    contact <= 1'b1;
                    if (release_req) begin
                        cnt   <= '0;
                        state <= BOUNCE_RELEASE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
`else
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            contact <= 1'b0;
            row_q   <= '0;
            col_q   <= '0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (press_req) begin
                        row_q   <= key_row(key_code);
                        col_q   <= key_col(key_code);
                        contact <= 1'b1;
                        state   <= HELD;
                        done    <= 1'b1;
                    end else begin
                        contact <= 1'b0;
                    end
                end
                HELD: begin
                    if (release_req) begin
                        contact <= 1'b0;
                        state   <= IDLE;
                        done    <= 1'b1;
                    end else begin
                        contact <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
`endif

    // NOTE: contact is async-cleared, so reset releases the columns without waiting for a clock.
    assign cols = (contact && (current_row == row_q)) ? ~(4'b0001 << col_q) : COLS_IDLE;
    assign busy = (state != IDLE);

endmodule

// File: tb/tb_keypad_matrix_emulator.sv
// Directed self-checking bench for keypad_matrix_emulator (both KEYPAD_EMU_BOUNCE_EN builds).
module tb_keypad_matrix_emulator;

`ifdef KEYPAD_EMU_BOUNCE_EN
    localparam int LAT = 16;
`else
    localparam int LAT = 0;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [1:0] current_row = 2'd0;
    logic [3:0] key_code = 4'h0;
    logic       press_req = 1'b0;
    logic       release_req = 1'b0;
    logic [3:0] cols;
    logic       busy;
    logic       done;

    int checks = 0;
    int failures = 0;

    logic [3:0] samp [0:16];
    logic [3:0] run1 [0:16];

    keypad_matrix_emulator #(
        .BOUNCE_CYCLES (16),
        .TOGGLE_DIV    (2),
        .LFSR_SEED     (8'hA5)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .current_row (current_row),
        .key_code    (key_code),
        .press_req   (press_req),
        .release_req (release_req),
        .cols        (cols),
        .busy        (busy),
        .done        (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Returns edges after the accepting edge until done is seen; records cols each cycle.
    task automatic wait_done(output int k);
        k = 0;
        samp[0] = cols;
        while (!done && k < LAT + 8) begin
            step();
            k++;
            if (k <= 16) samp[k] = cols;
        end
    endtask

    task automatic reset_and_idle();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        for (int i = 0; i < 10; i++) step();
    endtask

    task automatic press(input logic [3:0] key, output int k);
        key_code  = key;
        press_req = 1'b1;
        step();
        press_req = 1'b0;
        wait_done(k);
    endtask

    task automatic release_key(output int k);
        release_req = 1'b1;
        step();
        release_req = 1'b0;
        wait_done(k);
    endtask

    initial begin
        int k;
        int bad;
        int even_chg;
        int saw_low;

        // Reset holds columns released for every scanned row.
        #1 reset = 1'b1;
        for (int r = 0; r < 4; r++) begin
            current_row = 2'(r);
            #1;
            check($sformatf("rst_cols_r%0d", r), cols, 4'b1111);
        end
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        step();
        reset = 1'b0;
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            current_row = 2'(i);
            #1;
            if (cols !== 4'b1111 || busy !== 1'b0 || done !== 1'b0) bad++;
        end
        check("idle_10_cycles", bad, 0);

        // Press key 6 (row 1, col 2) while row 1 is scanned.
        current_row = 2'd1;
        key_code    = 4'h6;
        press_req   = 1'b1;
        step();
        press_req = 1'b0;
        check("press_busy", busy, 1);
        wait_done(k);
        check("press_latency", k, LAT);
        check("press_done", done, 1);
        for (int i = 0; i <= 16; i++) run1[i] = samp[i];
`ifdef KEYPAD_EMU_BOUNCE_EN
        bad = 0;
        even_chg = 0;
        saw_low = 0;
        for (int i = 1; i < 16; i++) begin
            if (samp[i] !== 4'b1011 && samp[i] !== 4'b1111) bad++;
            if ((i % 2) == 0 && samp[i] !== samp[i-1]) even_chg++;
            if (samp[i] === 4'b1011) saw_low = 1;
        end
        check("bounce_start_open", samp[0], 4'b1111);
        check("bounce_values", bad, 0);
        check("bounce_even_only", even_chg, 0);
        check("bounce_seen_closed", saw_low, 1);
`endif
        step();
        check("press_done_clear", done, 0);

        // Held key mapping across all rows.
        for (int r = 0; r < 4; r++) begin
            current_row = 2'(r);
            #1;
            check($sformatf("held_cols_r%0d", r), cols, (r == 1) ? 4'b1011 : 4'b1111);
        end
        current_row = 2'd1;

        // Release with a press attempted on every edge of the bounce window.
        release_req = 1'b1;
        step();
        release_req = 1'b0;
        k = 0;
        bad = 0;
        while (!done && k < LAT + 8) begin
            if (busy !== 1'b1) bad++;
            press_req = 1'b1;
            step();
            press_req = 1'b0;
            k++;
        end
        check("release_latency", k, LAT);
        check("release_busy_held", bad, 0);
        check("release_done", done, 1);
        check("release_busy", busy, 0);
        check("release_cols", cols, 4'b1111);
        step();
        check("press_not_queued", busy, 0);
        check("release_done_clear", done, 0);

        // release_req in IDLE is ignored.
        release_req = 1'b1;
        step();
        release_req = 1'b0;
        check("idle_release_busy", busy, 0);
        check("idle_release_done", done, 0);

        // Simultaneous press and release in IDLE: press wins.
        key_code    = 4'h6;
        press_req   = 1'b1;
        release_req = 1'b1;
        step();
        press_req   = 1'b0;
        release_req = 1'b0;
        check("both_req_busy", busy, 1);
        wait_done(k);
        check("both_req_latency", k, LAT);

        // key_code changes while held do not move the key.
        key_code = 4'hF;
        step();
        check("held_keep_r1", cols, 4'b1011);
        current_row = 2'd3;
        #1;
        check("held_keep_r3", cols, 4'b1111);
        current_row = 2'd1;

        // Asynchronous reset while held releases columns immediately.
        #1 reset = 1'b1;
        #1;
        check("async_rst_held_cols", cols, 4'b1111);
        check("async_rst_held_busy", busy, 0);
        step();
        reset = 1'b0;

`ifdef KEYPAD_EMU_BOUNCE_EN
        // Reset in the middle of the press bounce.
        key_code  = 4'h6;
        press_req = 1'b1;
        step();
        press_req = 1'b0;
        for (int i = 0; i < 5; i++) step();
        check("mid_bounce_busy", busy, 1);
        #1 reset = 1'b1;
        #1;
        check("mid_bounce_rst_cols", cols, 4'b1111);
        step();
        reset = 1'b0;
        step();
        check("mid_bounce_rst_idle", busy, 0);
`endif

        // Key C (row 3, col 0).
        press(4'hC, k);
        check("keyC_latency", k, LAT);
        current_row = 2'd3;
        #1;
        check("keyC_cols_r3", cols, 4'b1110);
        release_key(k);
        check("keyC_release_latency", k, LAT);
        check("keyC_release_cols", cols, 4'b1111);

        // Second run from reset must reproduce the first window exactly.
        current_row = 2'd0;
        reset_and_idle();
        current_row = 2'd1;
        press(4'h6, k);
        check("rerun_latency", k, LAT);
        bad = 0;
        for (int i = 0; i <= LAT; i++) if (samp[i] !== run1[i]) bad++;
        check("rerun_pattern", bad, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule
